cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
Shares one sram-like memory port, toward the AXI bridge, between the i_cache miss port (inst side) and the d_cache miss/writeback port (data side). Exactly one transaction is outstanding at a time. The block grants a requester, forwards its request, routes addr_ok/data_ok/rdata back to the owner only, then releases. It sits between the two caches and the sram-to-AXI bridge.

Parameters:
RR_EN, 1, 1 = round-robin when both request; 0 = fixed priority.
DATA_PRIO, 1, with RR_EN=0: 1 = data side wins ties, 0 = inst side wins.

Ports:
clk in 1 clock
rst in 1 asynchronous active-high reset
inst_req / data_req in 1 request from i_cache / d_cache
inst_wr / data_wr in 1 write flag
inst_size / data_size in 2 size code (0 = byte, 1 = half, 2 = word)
inst_addr / data_addr in 32 byte address
inst_wdata / data_wdata in 32 write data
inst_rdata / data_rdata out 32 read data to requester
inst_addr_ok / data_addr_ok out 1 address accepted, to requester
inst_data_ok / data_data_ok out 1 data phase complete, to requester
mem_req out 1 request to bridge
mem_wr out 1 write flag to bridge
mem_size out 2 size code to bridge
mem_addr out 32 address to bridge
mem_wdata out 32 write data to bridge
mem_rdata in 32 read data from bridge
mem_addr_ok in 1 address accepted by bridge
mem_data_ok in 1 data phase complete from bridge

Behaviour:
- Reset (async, rst=1): state=IDLE, owner=INST, last_grant=DATA (inst wins the first tie). All *_addr_ok, *_data_ok and mem_req are 0. Registers leave reset on the next clk edge after rst falls.
- States: IDLE, ADDR, DATA. sel = (state==IDLE) ? winner : owner.
- winner (combinational, IDLE only):
  - Only one side requesting: that side wins.
  - Both requesting, RR_EN=1: the side opposite last_grant wins.
  - Both requesting, RR_EN=0: data wins if DATA_PRIO=1, else inst.
- mem_req = req of sel side while state is IDLE or ADDR; mem_req=0 in DATA.
- mem_wr, mem_size, mem_addr and mem_wdata are muxed combinationally from the sel side in every state. They are registered nowhere, so requesters must hold them stable until data_ok.
- IDLE with any req: owner<=winner, last_grant<=winner.
  - mem_addr_ok in the same cycle: go to DATA (zero-wait grant).
  - Otherwise: go to ADDR.
- ADDR: on mem_addr_ok go to DATA; otherwise stay.
- DATA: on mem_data_ok go to IDLE. A new grant is evaluated in the following cycle, so there is a minimum 1-cycle gap between transactions.
- Response routing:
  - <sel>_addr_ok = mem_addr_ok & mem_req & state!=DATA.
  - <owner>_data_ok = mem_data_ok & state==DATA.
  - The non-owner always sees addr_ok=0 and data_ok=0.
  - inst_rdata and data_rdata both = mem_rdata; they are valid only when the matching data_ok is asserted.
- Spurious mem_data_ok in IDLE/ADDR, and spurious mem_addr_ok in DATA: ignored, no state change, not forwarded.
- Owner drops req while in ADDR: this is a protocol violation. mem_req follows it low, and the state stays ADDR until mem_addr_ok.
- Non-owner request: held off (addr_ok=0) until the owner's data_ok. With RR_EN=1 it is then served next, so there is no starvation.
- Latency: on a hit to a ready bridge, owner addr_ok comes in the same cycle as the request, and data_ok comes in the same cycle as mem_data_ok.

Decomposition:
- Shared package constants: state encoding (IDLE=2'b00, ADDR=2'b01, DATA=2'b10), side encoding (INST=1'b0, DATA=1'b1), sram-like size codes.
- One natural sub-module: arb_winner_sel, the combinational winner picker taking inst_req, data_req, last_grant, RR_EN and DATA_PRIO. Everything else stays in the top module.

Test Plan:
1. Reset mid-transaction: assert rst while in DATA -> state IDLE immediately; mem_req=0, all *_ok=0 asynchronously; the first post-reset tie goes to inst.
2. Single inst read: inst_req=1, addr=0xBFC00000, bridge addr_ok after 2 cycles, data_ok 3 cycles later with rdata=0x3C1D8000 -> inst_addr_ok pulses once, inst_data_ok pulses once with inst_rdata=0x3C1D8000; data_* outputs stay 0.
3. Simultaneous requests, RR_EN=1: both req every cycle over 4 transactions -> grant order inst, data, inst, data; mem_addr alternates 0xBFC00000 / 0x80001000.
4. RR_EN=0, DATA_PRIO=1: both requesting -> data served first; inst_addr_ok stays 0 until the cycle after data_data_ok, then inst is granted.
5. Zero-wait: mem_addr_ok tied 1, data write wr=1, size=2, wdata=0xDEADBEEF -> data_addr_ok in the request cycle; mem_wdata=0xDEADBEEF and mem_wr=1 until data_ok.
6. Spurious responses: mem_data_ok pulse in ADDR, and mem_addr_ok pulse in DATA -> no *_ok forwarded, state unchanged.

Source files
------------

// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types for the cache-to-bridge memory port arbiter.
// State, side and sram-like size encodings.
package cache_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  typedef enum logic {
    SIDE_INST = 1'b0,
    SIDE_DATA = 1'b1
  } side_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic side_t other_side(
    input side_t s
  );
    return (s == SIDE_INST) ? SIDE_DATA : SIDE_INST;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_arb_winner_sel.sv
// Combinational winner picker for the cache bus arbiter.
// Round-robin or fixed priority on a tie.
module arb_winner_sel
  import cache_bus_arbiter_pkg::*;
#(
  parameter bit RR_EN     = 1'b1,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic  inst_req,
  input  logic  data_req,
  input  side_t last_grant,
  output side_t winner
);

  side_t tie_winner;

  assign tie_winner = RR_EN ? other_side(last_grant)
                    : (DATA_PRIO ? SIDE_DATA : SIDE_INST);

  always_comb begin
    winner = SIDE_INST;
    unique case (1'b1)
      (inst_req & data_req):  winner = tie_winner;
      (data_req & ~inst_req): winner = SIDE_DATA;
      default:                winner = SIDE_INST;
    endcase
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one sram-like bridge port between i_cache and d_cache.
// One transaction outstanding; responses routed to the owner only.
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter bit RR_EN     = 1'b1,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  state_t state;
  side_t  owner;
  side_t  last_grant;
  side_t  winner;
  side_t  sel;
  logic   sel_req;
  logic   addr_ok_fwd;
  logic   data_ok_fwd;

  arb_winner_sel #(
    .RR_EN    (RR_EN),
    .DATA_PRIO(DATA_PRIO)
  ) u_winner_sel (
    .inst_req  (inst_req),
    .data_req  (data_req),
    .last_grant(last_grant),
    .winner    (winner)
  );

  assign sel = (state == ST_IDLE) ? winner : owner;

  assign sel_req = (sel == SIDE_DATA) ? data_req
                                      : inst_req;

  // Held low during reset even if a requester keeps req high.
  assign mem_req = ~rst & sel_req
                 & (state != ST_DATA);

  assign mem_wr    = (sel == SIDE_DATA) ? data_wr
                                        : inst_wr;
  assign mem_size  = (sel == SIDE_DATA) ? data_size
                                        : inst_size;
  assign mem_addr  = (sel == SIDE_DATA) ? data_addr
                                        : inst_addr;
  assign mem_wdata = (sel == SIDE_DATA) ? data_wdata
                                        : inst_wdata;

  assign addr_ok_fwd = mem_addr_ok & mem_req;
  assign data_ok_fwd = mem_data_ok
                     & (state == ST_DATA);

  assign inst_addr_ok = addr_ok_fwd
                      & (sel == SIDE_INST);
  assign data_addr_ok = addr_ok_fwd
                      & (sel == SIDE_DATA);
  assign inst_data_ok = data_ok_fwd
                      & (owner == SIDE_INST);
  assign data_data_ok = data_ok_fwd
                      & (owner == SIDE_DATA);

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= SIDE_INST;
      last_grant <= SIDE_DATA;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (inst_req | data_req) begin
            owner      <= winner;
            last_grant <= winner;
            state      <= mem_addr_ok ? ST_DATA
                                      : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (mem_addr_ok) state <= ST_DATA;
        end
        ST_DATA: begin
          if (mem_data_ok) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: directed scenarios plus random
// traffic against a cycle model, on RR and fixed-priority copies.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req, data_req;
  logic        inst_wr, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr;
  logic [31:0] inst_wdata, data_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  logic [31:0] o_irdata [2];
  logic [31:0] o_drdata [2];
  logic [31:0] o_maddr  [2];
  logic [31:0] o_mwdata [2];
  logic [1:0]  o_msize  [2];
  logic        o_iaok   [2];
  logic        o_daok   [2];
  logic        o_idok   [2];
  logic        o_ddok   [2];
  logic        o_mreq   [2];
  logic        o_mwr    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(
    .RR_EN(1'b1), .DATA_PRIO(1'b1)
  ) u_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(o_irdata[0]),
    .inst_addr_ok(o_iaok[0]), .inst_data_ok(o_idok[0]),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(o_drdata[0]),
    .data_addr_ok(o_daok[0]), .data_data_ok(o_ddok[0]),
    .mem_req(o_mreq[0]), .mem_wr(o_mwr[0]),
    .mem_size(o_msize[0]), .mem_addr(o_maddr[0]),
    .mem_wdata(o_mwdata[0]), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  cache_bus_arbiter #(
    .RR_EN(1'b0), .DATA_PRIO(1'b1)
  ) u_fp (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(o_irdata[1]),
    .inst_addr_ok(o_iaok[1]), .inst_data_ok(o_idok[1]),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(o_drdata[1]),
    .data_addr_ok(o_daok[1]), .data_data_ok(o_ddok[1]),
    .mem_req(o_mreq[1]), .mem_wr(o_mwr[1]),
    .mem_size(o_msize[1]), .mem_addr(o_maddr[1]),
    .mem_wdata(o_mwdata[1]), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  function automatic int pick(int rr, int dp,
                              bit ir, bit dr, int last);
    if (ir && dr) return rr != 0 ? 1 - last : dp;
    if (dr) return 1;
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    inst_req = 0; data_req = 0;
    inst_wr = 0; data_wr = 0;
    inst_size = 2'd2; data_size = 2'd2;
    inst_addr = 32'hBFC0_0000;
    data_addr = 32'h8000_1000;
    inst_wdata = 0; data_wdata = 0;
    mem_rdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    inst_req = 1;
    rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_mreq[k], o_iaok[k], o_daok[k],
           o_idok[k], o_ddok[k]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outs k=%0d got %b want 00000",
          k, {o_mreq[k], o_iaok[k], o_daok[k],
              o_idok[k], o_ddok[k]});
      end
    end
    do_reset();
    inst_req = 1;
    mem_addr_ok = 1;
    #1;
    tick();
    mem_addr_ok = 0;
    rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_mreq[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_async_req k=%0d got %b want 0",
          k, o_mreq[k]);
      end
    end
    mem_data_ok = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_idok[k], o_ddok[k]} !== 2'b0) begin
        errors++;
        $display("FAIL reset_async_dok k=%0d got %b want 00",
          k, {o_idok[k], o_ddok[k]});
      end
    end
    mem_data_ok = 0;
    data_req = 1;
    mem_addr_ok = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if ({o_iaok[0], o_daok[0], o_maddr[0]} !==
        {1'b1, 1'b0, 32'hBFC0_0000}) begin
      errors++;
      $display("FAIL reset_first_tie got %b%b %h want 10 bfc00000",
        o_iaok[0], o_daok[0], o_maddr[0]);
    end
    checks++;
    if ({o_iaok[1], o_daok[1]} !== 2'b01) begin
      errors++;
      $display("FAIL reset_fp_tie got %b%b want 01",
        o_iaok[1], o_daok[1]);
    end
    tick();
  endtask

  task automatic test_single_read;
    int ia_cnt, id_cnt, ia_cyc, id_cyc, side_bad;
    ia_cnt = 0; id_cnt = 0; side_bad = 0;
    ia_cyc = -1; id_cyc = -1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      inst_req = (c <= 5);
      mem_addr_ok = (c == 2);
      mem_data_ok = (c == 5);
      mem_rdata = (c == 5) ? 32'h3C1D_8000 : $urandom;
      #1;
      if (o_iaok[0]) begin ia_cnt++; ia_cyc = c; end
      if (o_daok[0] || o_ddok[0]) side_bad++;
      if (o_idok[0]) begin
        id_cnt++; id_cyc = c;
        checks++;
        if (o_irdata[0] !== 32'h3C1D_8000) begin
          errors++;
          $display("FAIL single_rdata got %h want 3c1d8000",
            o_irdata[0]);
        end
      end
      tick();
    end
    checks++;
    if (ia_cnt != 1 || ia_cyc != 2) begin
      errors++;
      $display("FAIL single_aok got n=%0d c=%0d want n=1 c=2",
        ia_cnt, ia_cyc);
    end
    checks++;
    if (id_cnt != 1 || id_cyc != 5) begin
      errors++;
      $display("FAIL single_dok got n=%0d c=%0d want n=1 c=5",
        id_cnt, id_cyc);
    end
    checks++;
    if (side_bad != 0) begin
      errors++;
      $display("FAIL single_data_side got %0d want 0",
        side_bad);
    end
    idle_inputs();
  endtask

  task automatic test_round_robin;
    int          g_side[$];
    logic [31:0] g_addr[$];
    do_reset();
    inst_req = 1; data_req = 1;
    mem_addr_ok = 1; mem_data_ok = 1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (o_iaok[0]) begin
        g_side.push_back(0); g_addr.push_back(o_maddr[0]);
      end
      if (o_daok[0]) begin
        g_side.push_back(1); g_addr.push_back(o_maddr[0]);
      end
      tick();
    end
    checks++;
    if (g_side.size() != 4) begin
      errors++;
      $display("FAIL rr_count got %0d want 4", g_side.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g_side[i] != (i % 2) ||
            g_addr[i] !== ((i % 2) != 0 ? 32'h8000_1000
                                        : 32'hBFC0_0000)) begin
          errors++;
          $display("FAIL rr_grant%0d got side %0d addr %h want %0d",
            i, g_side[i], g_addr[i], i % 2);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_fixed_prio;
    int first_ia, dd_cyc, da_cyc;
    first_ia = -1; dd_cyc = -1; da_cyc = -1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      inst_req = 1;
      data_req = (c <= 3);
      mem_addr_ok = (c == 1 || c == 4);
      mem_data_ok = (c == 3);
      #1;
      if (o_iaok[1] && first_ia < 0) first_ia = c;
      if (o_daok[1] && da_cyc < 0) da_cyc = c;
      if (o_ddok[1] && dd_cyc < 0) dd_cyc = c;
      tick();
    end
    checks++;
    if (da_cyc != 1 || dd_cyc != 3) begin
      errors++;
      $display("FAIL fp_data_first got a=%0d d=%0d want 1 3",
        da_cyc, dd_cyc);
    end
    checks++;
    if (first_ia != 4) begin
      errors++;
      $display("FAIL fp_inst_after got %0d want 4", first_ia);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_zero_wait;
    do_reset();
    data_wr = 1; data_size = 2'd2;
    data_wdata = 32'hDEAD_BEEF;
    data_addr = 32'h8000_2000;
    for (int c = 0; c < 3; c++) begin
      data_req = 1;
      mem_addr_ok = 1;
      mem_data_ok = (c == 2);
      #1;
      checks++;
      if ({o_mwr[0], o_msize[0], o_mwdata[0]} !==
          {1'b1, 2'd2, 32'hDEAD_BEEF}) begin
        errors++;
        $display("FAIL zw_mux c=%0d got %b %0d %h want 1 2 deadbeef",
          c, o_mwr[0], o_msize[0], o_mwdata[0]);
      end
      checks++;
      if ({o_mreq[0], o_daok[0], o_ddok[0]} !==
          {c == 0, c == 0, c == 2}) begin
        errors++;
        $display("FAIL zw_ctl c=%0d got %b want %b", c,
          {o_mreq[0], o_daok[0], o_ddok[0]},
          {c == 0, c == 0, c == 2});
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_spurious;
    logic [4:0] ev, av;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      inst_req = 1;
      mem_addr_ok = (c == 2 || c == 3);
      mem_data_ok = (c == 1 || c == 4);
      #1;
      ev = {c <= 2, c == 2, c == 4, 1'b0, 1'b0};
      av = {o_mreq[0], o_iaok[0], o_idok[0],
            o_daok[0], o_ddok[0]};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL spur c=%0d got %b want %b", c, av, ev);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random;
    int ph[2], own[2], last[2];
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; own[k] = 0; last[k] = 1;
    end
    for (int n = 0; n < 3000; n++) begin
      inst_req = 1'($urandom_range(0, 1));
      data_req = 1'($urandom_range(0, 1));
      inst_wr = 1'($urandom_range(0, 1));
      data_wr = 1'($urandom_range(0, 1));
      inst_size = 2'($urandom_range(0, 2));
      data_size = 2'($urandom_range(0, 2));
      inst_addr = $urandom; data_addr = $urandom;
      inst_wdata = $urandom; data_wdata = $urandom;
      mem_rdata = $urandom;
      mem_addr_ok = ($urandom_range(0, 2) == 0);
      mem_data_ok = ($urandom_range(0, 2) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        int w, s;
        bit er;
        logic [4:0] ev, av;
        logic [66:0] em, am;
        w = pick(k == 0 ? 1 : 0, 1, inst_req,
                 data_req, last[k]);
        s = (ph[k] == 0) ? w : own[k];
        er = (ph[k] != 2) &&
             ((s == 1) ? data_req : inst_req);
        ev = {er,
              mem_addr_ok && er && s == 0,
              mem_addr_ok && er && s == 1,
              mem_data_ok && ph[k] == 2 && own[k] == 0,
              mem_data_ok && ph[k] == 2 && own[k] == 1};
        av = {o_mreq[k], o_iaok[k], o_daok[k],
              o_idok[k], o_ddok[k]};
        checks++;
        if (av !== ev) begin
          errors++;
          $display("FAIL rnd_ctl k=%0d n=%0d got %b want %b",
            k, n, av, ev);
        end
        if (ph[k] != 0 || inst_req || data_req) begin
          em = (s == 1)
             ? {data_wr, data_size, data_addr, data_wdata}
             : {inst_wr, inst_size, inst_addr, inst_wdata};
          am = {o_mwr[k], o_msize[k], o_maddr[k],
                o_mwdata[k]};
          checks++;
          if (am !== em) begin
            errors++;
            $display("FAIL rnd_mux k=%0d n=%0d got %h want %h",
              k, n, am, em);
          end
        end
        if (ev[1] || ev[0]) begin
          checks++;
          if ((ev[1] ? o_irdata[k] : o_drdata[k])
              !== mem_rdata) begin
            errors++;
            $display("FAIL rnd_rdata k=%0d n=%0d want %h",
              k, n, mem_rdata);
          end
        end
        if (ph[k] == 0) begin
          if (inst_req || data_req) begin
            own[k] = w; last[k] = w;
            ph[k] = mem_addr_ok ? 2 : 1;
          end
        end else if (ph[k] == 1) begin
          if (mem_addr_ok) ph[k] = 2;
        end else if (mem_data_ok) begin
          ph[k] = 0;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_prio();
    test_zero_wait();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
